// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared FSM state type and default geometry for the data
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int c_default_addr_bits   = 8;
    localparam int c_default_wait_states = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module      : dmem_array
// Description : Single-port word storage, synchronous write, combinational
//               read. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_wdata,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : dmem_array

`default_nettype wire

// File: rtl/data_memory_responder.sv
// ============================================================================
// Module      : data_memory_responder
// Description : Request/response front end for a word-addressed data memory
//               with a fixed wait-state count and out-of-range rejection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = c_default_addr_bits,
    parameter int WAIT_STATES = c_default_wait_states
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] address_rw,
    input  logic [15:0] data_in,
    output logic        resp_valid,
    output logic [15:0] data_out,
    output logic        error
);

    localparam bit         c_zero_wait = (WAIT_STATES == 0);
    localparam logic [3:0] c_wait_load = 4'(WAIT_STATES);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_count;
    logic        r_rst_done;
    logic        r_write;
    logic        r_error;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_data_out;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_c_write;
    logic        w_oor;
    logic        w_mem_we;
    logic [15:0] w_c_addr;
    logic [15:0] w_c_wdata;
    logic [15:0] w_rdata;

    assign w_accept     = req_valid & req_ready;
    assign w_enter_resp = (w_next_state == RESP);

    // With no wait states the commit happens on the accepting edge itself,
    // so the live request fields are used instead of the latched copies.
    assign w_c_write = c_zero_wait ? req_write  : r_write;
    assign w_c_addr  = c_zero_wait ? address_rw : r_addr;
    assign w_c_wdata = c_zero_wait ? data_in    : r_wdata;

    generate
        if (ADDR_BITS < 16) begin : g_range_check
            assign w_oor = |w_c_addr[15:ADDR_BITS];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_mem_we = rst & w_enter_resp & w_c_write & ~w_oor;

    dmem_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (16)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_c_addr[ADDR_BITS-1:0]),
        .i_wdata (w_c_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = c_zero_wait ? RESP : WAIT;
            end
            WAIT: begin
                if (r_count == 4'd1) w_next_state = RESP;
            end
            RESP: begin
                if (w_accept) w_next_state = c_zero_wait ? RESP : WAIT;
                else          w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = r_rst_done && (r_state != WAIT);
        resp_valid = (r_state == RESP);
        error      = r_error;
        data_out   = r_data_out;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= 4'd0;
            r_rst_done <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_error    <= 1'b0;
            r_data_out <= 16'h0000;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= address_rw;
                r_wdata <= data_in;
                r_count <= c_wait_load;
            end else if (r_state == WAIT) begin
                r_count <= r_count - 4'd1;
            end
            r_error <= 1'b0;
            if (w_enter_resp) begin
                r_error    <= w_oor;
                r_data_out <= w_oor ? 16'h0000 : (w_c_write ? w_c_wdata : w_rdata);
            end
        end
    end

endmodule : data_memory_responder

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
// ============================================================================
// Module      : tb_data_memory_responder
// Description : Three responder instances (0, 2 and 3 wait states) checked
//               cycle by cycle against a request/due-time memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_responder;

    localparam int NI = 3;
    localparam int WSV [NI] = '{2, 0, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rstn, rv, rw, rr, vv, er;
    logic [15:0]   ad [NI];
    logic [15:0]   di [NI];
    logic [15:0]   dq [NI];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .rst(rstn[0]), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_write(rw[0]), .address_rw(ad[0]), .data_in(di[0]),
        .resp_valid(vv[0]), .data_out(dq[0]), .error(er[0]));

    data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst(rstn[1]), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_write(rw[1]), .address_rw(ad[1]), .data_in(di[1]),
        .resp_valid(vv[1]), .data_out(dq[1]), .error(er[1]));

    data_memory_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) u_dut2 (
        .clk(clk), .rst(rstn[2]), .req_valid(rv[2]), .req_ready(rr[2]),
        .req_write(rw[2]), .address_rw(ad[2]), .data_in(di[2]),
        .resp_valid(vv[2]), .data_out(dq[2]), .error(er[2]));

    task automatic chk(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
        end
    endtask

    // Model: each accepted request is due WAIT_STATES cycles after the
    // accepting edge; the memory image is updated when it falls due.
    bit          started [NI];
    bit          rok     [NI];
    bit          pend    [NI];
    int          due     [NI];
    bit          pw      [NI];
    logic [15:0] pa      [NI];
    logic [15:0] pd      [NI];
    bit          e_rdy   [NI];
    bit          e_vld   [NI];
    bit          e_err   [NI];
    bit          e_known [NI];
    logic [15:0] e_dat   [NI];
    logic [15:0] mem     [NI][256];
    bit          mk      [NI][256];

    task automatic model_step();
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (rstn[i] !== 1'b1) begin
                started[i] = 1'b1;
                rok[i]     = 1'b0;
                pend[i]    = 1'b0;
                e_vld[i]   = 1'b0;
                e_err[i]   = 1'b0;
                e_dat[i]   = 16'h0000;
                e_known[i] = 1'b1;
            end else if (started[i]) begin
                e_vld[i] = 1'b0;
                e_err[i] = 1'b0;
                if (rv[i] && e_rdy[i]) begin
                    pend[i] = 1'b1;
                    due[i]  = cyc + WSV[i];
                    pw[i]   = rw[i];
                    pa[i]   = ad[i];
                    pd[i]   = di[i];
                end
                if (pend[i] && due[i] == cyc) begin
                    pend[i]  = 1'b0;
                    e_vld[i] = 1'b1;
                    if (pa[i][15:8] != 8'h00) begin
                        e_err[i]   = 1'b1;
                        e_dat[i]   = 16'h0000;
                        e_known[i] = 1'b1;
                    end else if (pw[i]) begin
                        mem[i][pa[i][7:0]] = pd[i];
                        mk[i][pa[i][7:0]]  = 1'b1;
                        e_dat[i]   = pd[i];
                        e_known[i] = 1'b1;
                    end else begin
                        e_dat[i]   = mem[i][pa[i][7:0]];
                        e_known[i] = mk[i][pa[i][7:0]];
                    end
                end
                rok[i] = 1'b1;
            end
            e_rdy[i] = rok[i] && !pend[i];
            if (started[i]) begin
                chk("ready", i, 32'(rr[i]), 32'(e_rdy[i]));
                chk("resp_valid", i, 32'(vv[i]), 32'(e_vld[i]));
                chk("error", i, 32'(er[i]), 32'(e_err[i]));
                if (e_known[i]) chk("data_out", i, 32'(dq[i]), 32'(e_dat[i]));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i);
        int guard = 0;
        while (!rr[i] && guard < 20) begin
            step();
            guard++;
        end
        if (!rr[i]) chk("ready_timeout", i, 32'(rr[i]), 32'd1);
    endtask

    task automatic do_req(input int i, input logic w, input logic [15:0] a,
                          input logic [15:0] d, output int lat,
                          output logic [15:0] q, output logic e);
        wait_ready(i);
        rv[i] = 1'b1; rw[i] = w; ad[i] = a; di[i] = d;
        step();
        rv[i] = 1'b0; rw[i] = 1'($urandom); ad[i] = 16'($urandom); di[i] = 16'($urandom);
        lat = 1;
        while (!vv[i] && lat < 20) begin
            step();
            lat++;
        end
        q = dq[i];
        e = er[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic [15:0] q;
        logic        e;
        int          accs, resps, run, highs;

        rstn = '0; rv = '0; rw = '0;
        for (int i = 0; i < NI; i++) begin ad[i] = 16'h0; di[i] = 16'h0; end
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", i, 32'(rr[i]), 32'd0);
            chk("rst_valid", i, 32'(vv[i]), 32'd0);
            chk("rst_error", i, 32'(er[i]), 32'd0);
            chk("rst_data", i, 32'(dq[i]), 32'h0000);
        end
        rstn = '1;
        step();
        chk("ready_after_rst", 0, 32'(rr), 32'b111);

        // Write then read with two wait states.
        do_req(0, 1'b1, 16'h0010, 16'hBEEF, lat, q, e);
        chk("wr_latency", 0, lat, 3);
        do_req(0, 1'b0, 16'h0010, 16'h0000, lat, q, e);
        chk("rd_latency", 0, lat, 3);
        chk("rd_data", 0, 32'(q), 32'hBEEF);
        chk("rd_error", 0, 32'(e), 32'd0);

        // Back-to-back with zero wait states.
        wait_ready(1);
        rv[1] = 1'b1; rw[1] = 1'b1; ad[1] = 16'h0005; di[1] = 16'h1234;
        step();
        highs = vv[1] ? 1 : 0;
        chk("b2b_wr_data", 1, 32'(dq[1]), 32'h1234);
        chk("b2b_rd_ready", 1, 32'(rr[1]), 32'd1);
        rw[1] = 1'b0; di[1] = 16'hFFFF;
        step();
        rv[1] = 1'b0;
        if (vv[1]) highs++;
        chk("b2b_rd_data", 1, 32'(dq[1]), 32'h1234);
        step();
        chk("b2b_highs", 1, highs, 2);
        chk("b2b_idle_valid", 1, 32'(vv[1]), 32'd0);
        chk("b2b_hold", 1, 32'(dq[1]), 32'h1234);

        // Out-of-range write must not alias onto address 0.
        do_req(0, 1'b1, 16'h0000, 16'h0F0F, lat, q, e);
        do_req(0, 1'b1, 16'h0100, 16'hAAAA, lat, q, e);
        chk("oor_error", 0, 32'(e), 32'd1);
        chk("oor_data", 0, 32'(q), 32'h0000);
        do_req(0, 1'b0, 16'h0000, 16'h0000, lat, q, e);
        chk("alias_data", 0, 32'(q), 32'h0F0F);
        chk("alias_error", 0, 32'(e), 32'd0);

        // Reset during WAIT drops the pending write.
        do_req(0, 1'b1, 16'h0020, 16'h1111, lat, q, e);
        wait_ready(0);
        rv[0] = 1'b1; rw[0] = 1'b1; ad[0] = 16'h0020; di[0] = 16'h5555;
        step();
        rv[0] = 1'b0;
        rstn[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("midrst_valid", 0, 32'(vv[0]), 32'd0);
            chk("midrst_ready", 0, 32'(rr[0]), 32'd0);
            chk("midrst_data", 0, 32'(dq[0]), 32'h0000);
        end
        rstn[0] = 1'b1;
        step();
        chk("midrst_ready_up", 0, 32'(rr[0]), 32'd1);
        do_req(0, 1'b0, 16'h0020, 16'h0000, lat, q, e);
        chk("midrst_rd", 0, 32'(q), 32'h1111);

        // Continuous requests with three wait states.
        wait_ready(2);
        accs = 0; resps = 0; run = 0;
        rv[2] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (rr[2]) begin
                accs++;
                if (run > 0) chk("hold_low_run", 2, run, 3);
                run = 0;
            end else begin
                run++;
            end
            if (vv[2]) resps++;
            rw[2] = 1'($urandom); ad[2] = 16'($urandom_range(0, 15)); di[2] = 16'($urandom);
            step();
        end
        rv[2] = 1'b0;
        repeat (8) begin
            if (vv[2]) resps++;
            step();
        end
        chk("hold_accepts", 2, accs, 8);
        chk("hold_resps", 2, resps, accs);

        // Randomized traffic on all instances, including occasional resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NI; i++) begin
                rv[i]   = ($urandom_range(0, 99) < 60);
                rw[i]   = 1'($urandom);
                ad[i]   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                di[i]   = 16'($urandom);
                rstn[i] = ($urandom_range(0, 149) != 0);
            end
            step();
        end
        rstn = '1; rv = '0;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_memory_responder

`default_nettype wire
